// File: rtl/ddr3_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_test_pkg
// Purpose  : Shared types and constants for the DDR3 loopback traffic checker.
// Revision : 1.0
// ============================================================================
package ddr3_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } test_state_t;

    typedef enum logic [1:0] {
        PAT_INC  = 2'd0,
        PAT_LFSR = 2'd1,
        PAT_WALK = 2'd2,
        PAT_ADDR = 2'd3
    } pattern_mode_t;

    // Right-shifting Galois feedback masks for maximal-length sequences.
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            4:       return 64'h0000_0000_0000_000C;
            8:       return 64'h0000_0000_0000_00B8;
            12:      return 64'h0000_0000_0000_0E08;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_8020_0003;
            64:      return 64'hD800_0000_0000_0000;
            default: return 64'd1 << (width - 1);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_test_pattern_gen
// Purpose  : Word generator for one side (write or check) of the loopback test.
//            LFSR words are only built when LFSR_PATTERN_EN is defined.
// Revision : 1.0
// ============================================================================
module ddr3_test_pattern_gen
    import ddr3_test_pkg::*;
#(
    parameter int DQ_BITWIDTH   = 16,
    parameter int ADDR_BITWIDTH = 17,
    parameter int SEED          = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_load,
    input  logic                     i_advance,
    input  pattern_mode_t            i_mode,
    input  logic [ADDR_BITWIDTH-1:0] i_addr,
    output logic [DQ_BITWIDTH-1:0]   o_word
);

    localparam int WW = (DQ_BITWIDTH > 1) ? $clog2(DQ_BITWIDTH) : 1;
    localparam logic [WW-1:0]          c_WALK_LAST = WW'(DQ_BITWIDTH - 1);
    localparam logic [DQ_BITWIDTH-1:0] c_SEED      = DQ_BITWIDTH'(SEED);

    logic [DQ_BITWIDTH-1:0] r_inc;
    logic [WW-1:0]          r_walk;
    logic [DQ_BITWIDTH-1:0] w_addr_word;

    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_inc  <= c_SEED;
            r_walk <= '0;
        end else if (i_advance) begin
            r_inc  <= r_inc + DQ_BITWIDTH'(1);
            r_walk <= (r_walk == c_WALK_LAST) ? '0 : r_walk + WW'(1);
        end
    end

    assign w_addr_word = DQ_BITWIDTH'(i_addr);

`ifdef LFSR_PATTERN_EN
    localparam logic [DQ_BITWIDTH-1:0] c_TAPS = DQ_BITWIDTH'(lfsr_taps(DQ_BITWIDTH));
    logic [DQ_BITWIDTH-1:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_lfsr <= c_SEED;
        end else if (i_advance) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ c_TAPS) : (r_lfsr >> 1);
        end
    end

    always_comb begin
        o_word = r_inc;
        case (i_mode)
            PAT_LFSR: o_word = r_lfsr;
            PAT_WALK: o_word = DQ_BITWIDTH'(1) << r_walk;
            PAT_ADDR: o_word = w_addr_word;
            default:  o_word = r_inc;
        endcase
    end
`else
    // Mode 1 falls through to the incrementing pattern.
    always_comb begin
        o_word = r_inc;
        case (i_mode)
            PAT_WALK: o_word = DQ_BITWIDTH'(1) << r_walk;
            PAT_ADDR: o_word = w_addr_word;
            default:  o_word = r_inc;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/ddr3_loopback_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_loopback_traffic_checker
// Purpose  : Writes a patterned block through the DDR3 controller, reads it
//            back and scores the returned words. Option: LFSR_PATTERN_EN.
// Revision : 1.0
// ============================================================================
module ddr3_loopback_traffic_checker
    import ddr3_test_pkg::*;
#(
    parameter int DQ_BITWIDTH           = 16,
    parameter int ADDRESS_BITWIDTH      = 14,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int STATE_BITWIDTH        = 5,
    parameter int STATE_WRITE_DATA      = 8,
    parameter int STATE_READ_DATA       = 11,
    parameter int NUM_OF_TEST_DATA      = 64,
    parameter int BASE_ADDRESS          = 0,
    parameter int ADDRESS_STRIDE        = 1,
    parameter int SEED                  = 1,
    parameter int READ_TIMEOUT          = 4096,
    parameter int ERR_CNT_BITWIDTH      = 16
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic [1:0]                                        pattern_mode,
    input  logic [STATE_BITWIDTH-1:0]                         main_state,
    input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
    input  logic                                              data_from_ram_valid,
    output logic                                              write_enable,
    output logic                                              read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              pass,
    output logic [ERR_CNT_BITWIDTH-1:0]                       error_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address,
    output logic [DQ_BITWIDTH-1:0]                            first_error_data
);

    localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int CW = $clog2(NUM_OF_TEST_DATA + 1);
    localparam int TW = $clog2(READ_TIMEOUT + 1);

    localparam logic [CW-1:0]             c_N        = CW'(NUM_OF_TEST_DATA);
    localparam logic [CW-1:0]             c_N_LAST   = CW'(NUM_OF_TEST_DATA - 1);
    localparam logic [AW-1:0]             c_BASE     = AW'(BASE_ADDRESS);
    localparam logic [AW-1:0]             c_STRIDE   = AW'(ADDRESS_STRIDE);
    localparam logic [TW-1:0]             c_TO_LAST  = TW'(READ_TIMEOUT - 1);
    localparam logic [STATE_BITWIDTH-1:0] c_ST_WR    = STATE_BITWIDTH'(STATE_WRITE_DATA);
    localparam logic [STATE_BITWIDTH-1:0] c_ST_RD    = STATE_BITWIDTH'(STATE_READ_DATA);
    localparam logic [32:0]               c_ERR_MAX  = (33'd1 << ERR_CNT_BITWIDTH) - 33'd1;

    test_state_t               r_state;
    pattern_mode_t             r_mode;
    logic                      r_we;
    logic                      r_re;
    logic [AW-1:0]             r_addr;
    logic [AW-1:0]             r_chk_addr;
    logic                      r_busy;
    logic                      r_done;
    logic [ERR_CNT_BITWIDTH-1:0] r_err;
    logic                      r_first_seen;
    logic [AW-1:0]             r_fe_addr;
    logic [DQ_BITWIDTH-1:0]    r_fe_data;
    logic [CW-1:0]             r_wr_cnt;
    logic [CW-1:0]             r_rd_cnt;
    logic [CW-1:0]             r_rcv_cnt;
    logic [TW-1:0]             r_timer;

    logic                        w_start_ok;
    logic                        w_wr_fire;
    logic                        w_rd_fire;
    logic                        w_checking;
    logic                        w_accept;
    logic                        w_mismatch;
    logic                        w_outstanding;
    logic                        w_timeout;
    logic [CW-1:0]               w_rcv_next;
    logic [ERR_CNT_BITWIDTH:0]   w_err_inc;
    logic [ERR_CNT_BITWIDTH-1:0] w_err_plus1;
    logic [32:0]                 w_err_sum;
    logic [ERR_CNT_BITWIDTH-1:0] w_err_plus_miss;
    logic [DQ_BITWIDTH-1:0]      w_wr_word;
    logic [DQ_BITWIDTH-1:0]      w_chk_word;

    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_wr_fire  = (r_state == S_WRITE) && (main_state == c_ST_WR);
    assign w_rd_fire  = (r_state == S_READ) && (main_state == c_ST_RD);
    assign w_checking = (r_state == S_READ) || (r_state == S_DRAIN);
    assign w_accept   = w_checking && data_from_ram_valid && (r_rcv_cnt != c_N);
    assign w_mismatch = w_accept && (data_from_ram != w_chk_word);
    assign w_rcv_next = r_rcv_cnt + CW'(w_accept);

    // During S_READ only issued-but-unanswered reads count as outstanding.
    assign w_outstanding = (r_state == S_READ) ? (r_rd_cnt != r_rcv_cnt) : (r_rcv_cnt != c_N);
    assign w_timeout     = w_checking && !w_accept && w_outstanding && (r_timer == c_TO_LAST);

    assign w_err_inc       = {1'b0, r_err} + (ERR_CNT_BITWIDTH + 1)'(1);
    assign w_err_plus1     = w_err_inc[ERR_CNT_BITWIDTH] ? '1 : w_err_inc[ERR_CNT_BITWIDTH-1:0];
    assign w_err_sum       = 33'(r_err) + 33'(c_N - r_rcv_cnt);
    assign w_err_plus_miss = (w_err_sum > c_ERR_MAX) ? '1 : w_err_sum[ERR_CNT_BITWIDTH-1:0];

    ddr3_test_pattern_gen #(
        .DQ_BITWIDTH   (DQ_BITWIDTH),
        .ADDR_BITWIDTH (AW),
        .SEED          (SEED)
    ) u_wr_gen (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_start_ok),
        .i_advance (w_wr_fire),
        .i_mode    (r_mode),
        .i_addr    (r_addr),
        .o_word    (w_wr_word)
    );

    ddr3_test_pattern_gen #(
        .DQ_BITWIDTH   (DQ_BITWIDTH),
        .ADDR_BITWIDTH (AW),
        .SEED          (SEED)
    ) u_chk_gen (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_start_ok),
        .i_advance (w_accept),
        .i_mode    (r_mode),
        .i_addr    (r_chk_addr),
        .o_word    (w_chk_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mode       <= PAT_INC;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_addr       <= '0;
            r_chk_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= '0;
            r_first_seen <= 1'b0;
            r_fe_addr    <= '0;
            r_fe_data    <= '0;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_rcv_cnt    <= '0;
            r_timer      <= '0;
        end else begin
            if (w_accept) begin
                r_rcv_cnt  <= w_rcv_next;
                r_chk_addr <= r_chk_addr + c_STRIDE;
                if (w_mismatch) begin
                    r_err <= w_err_plus1;
                    if (!r_first_seen) begin
                        r_first_seen <= 1'b1;
                        r_fe_addr    <= r_chk_addr;
                        r_fe_data    <= data_from_ram;
                    end
                end
            end
            if (w_checking) begin
                r_timer <= (w_accept || !w_outstanding) ? '0 : r_timer + TW'(1);
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_WRITE;
                        r_mode       <= pattern_mode_t'(pattern_mode);
                        r_we         <= 1'b1;
                        r_re         <= 1'b0;
                        r_addr       <= c_BASE;
                        r_chk_addr   <= c_BASE;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= '0;
                        r_first_seen <= 1'b0;
                        r_fe_addr    <= '0;
                        r_fe_data    <= '0;
                        r_wr_cnt     <= '0;
                        r_rd_cnt     <= '0;
                        r_rcv_cnt    <= '0;
                        r_timer      <= '0;
                    end
                end
                S_WRITE: begin
                    if (w_wr_fire) begin
                        r_wr_cnt <= r_wr_cnt + CW'(1);
                        if (r_wr_cnt == c_N_LAST) begin
                            r_we    <= 1'b0;
                            r_re    <= 1'b1;
                            r_addr  <= c_BASE;
                            r_state <= S_READ;
                        end else begin
                            r_addr <= r_addr + c_STRIDE;
                        end
                    end
                end
                S_READ: begin
                    if (w_rd_fire) begin
                        r_addr   <= r_addr + c_STRIDE;
                        r_rd_cnt <= r_rd_cnt + CW'(1);
                        if (r_rd_cnt == c_N_LAST) begin
                            r_re    <= 1'b0;
                            r_state <= S_DRAIN;
                        end
                    end
                    if (w_timeout) begin
                        r_err   <= w_err_plus_miss;
                        r_re    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (w_timeout) begin
                        r_err <= w_err_plus_miss;
                    end
                    if (w_timeout || (w_rcv_next == c_N)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign write_enable        = r_we;
    assign read_enable         = r_re;
    assign i_user_data_address = r_addr;
    assign data_to_ram         = r_we ? w_wr_word : '0;
    assign busy                = r_busy;
    assign done                = r_done;
    assign pass                = r_done && (r_err == '0);
    assign error_count         = r_err;
    assign first_error_address = r_fe_addr;
    assign first_error_data    = r_fe_data;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_loopback_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_loopback_traffic_checker
// Purpose  : Randomised loopback bench with a memory/controller model.
// Revision : 1.0
// ============================================================================
module tb_ddr3_loopback_traffic_checker;

    localparam int DQ = 16, AB = 14, BB = 3, SB = 5, AW = 17;
    localparam int ST_WR = 8, ST_RD = 11;
    localparam int N = 64, BASE = 0, STRIDE = 1, SEED = 1, TO = 4096, EB = 16;

    logic          clk = 1'b0;
    logic          reset, start, data_from_ram_valid;
    logic [1:0]    pattern_mode;
    logic [SB-1:0] main_state;
    logic [DQ-1:0] data_from_ram;
    logic          write_enable, read_enable, busy, done, pass;
    logic [AW-1:0] i_user_data_address, first_error_address;
    logic [DQ-1:0] data_to_ram, first_error_data;
    logic [EB-1:0] error_count;

    ddr3_loopback_traffic_checker #(
        .DQ_BITWIDTH(DQ), .ADDRESS_BITWIDTH(AB), .BANK_ADDRESS_BITWIDTH(BB),
        .STATE_BITWIDTH(SB), .STATE_WRITE_DATA(ST_WR), .STATE_READ_DATA(ST_RD),
        .NUM_OF_TEST_DATA(N), .BASE_ADDRESS(BASE), .ADDRESS_STRIDE(STRIDE),
        .SEED(SEED), .READ_TIMEOUT(TO), .ERR_CNT_BITWIDTH(EB)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pattern_mode(pattern_mode),
        .main_state(main_state), .data_from_ram(data_from_ram),
        .data_from_ram_valid(data_from_ram_valid), .write_enable(write_enable),
        .read_enable(read_enable), .i_user_data_address(i_user_data_address),
        .data_to_ram(data_to_ram), .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .first_error_address(first_error_address),
        .first_error_data(first_error_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rd_req_t;

    rd_req_t       rq[$];
    logic [DQ-1:0] mem[int];
    int checks = 0, errors = 0, cyc = 0;
    int wr_k, rd_k, rsp_k, cur_mode, ci, drop, ms_mode, last_valid_cyc;
    logic [DQ-1:0] xr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int k);
        return AW'(BASE + k * STRIDE);
    endfunction

    function automatic logic [DQ-1:0] exp_word(input int mode, input int k);
        logic [AW-1:0] a;
        logic [DQ-1:0] v;
        a = exp_addr(k);
        case (mode)
            2:       v = DQ'(1) << (k % DQ);
            3:       v = a[DQ-1:0];
`ifdef LFSR_PATTERN_EN
            1: begin
                v = DQ'(SEED);
                repeat (k) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
            end
`endif
            default: v = DQ'(SEED + k);
        endcase
        return v;
    endfunction

    // One cycle of controller + memory behaviour, acting between clock edges.
    task automatic tick();
        logic [SB-1:0] ms;
        rd_req_t       r;
        int            k;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        if (ms_mode == 1) begin
            ms = (cyc % 2 == 1) ? (write_enable ? SB'(ST_WR) : (read_enable ? SB'(ST_RD) : SB'(0))) : SB'(3);
        end else if (write_enable) begin
            ms = ($urandom_range(0, 2) == 0) ? SB'(3) : SB'(ST_WR);
        end else if (read_enable) begin
            ms = ($urandom_range(0, 2) == 0) ? SB'(3) : SB'(ST_RD);
        end else begin
            ms = ($urandom_range(0, 1) == 0) ? SB'(0) : SB'(ST_RD);
        end
        main_state = ms;
        if (ms == SB'(ST_WR) && write_enable) begin
            chk("wr_addr", i_user_data_address, exp_addr(wr_k));
            chk("wr_data", data_to_ram, exp_word(cur_mode, wr_k));
            mem[int'(i_user_data_address)] = data_to_ram;
            wr_k++;
        end
        if (ms == SB'(ST_RD) && read_enable) begin
            chk("rd_addr", i_user_data_address, exp_addr(rd_k));
            r.addr = i_user_data_address;
            r.due  = cyc + $urandom_range(1, 5);
            rq.push_back(r);
            rd_k++;
        end
        data_from_ram_valid = 1'b0;
        data_from_ram       = DQ'($urandom);
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            k = rsp_k++;
            if (k < N - drop) begin
                data_from_ram_valid = 1'b1;
                data_from_ram = (mem.exists(int'(r.addr)) ? mem[int'(r.addr)] : 16'hDEAD)
                              ^ ((k == ci) ? xr : DQ'(0));
                last_valid_cyc = cyc;
            end
        end
    endtask

    task automatic start_pass(input int mode, input int c_i, input logic [DQ-1:0] x, input int d, input int msm);
        cur_mode = mode; ci = c_i; xr = x; drop = d; ms_mode = msm;
        wr_k = 0; rd_k = 0; rsp_k = 0;
        rq.delete();
        @(negedge clk);
        start = 1'b1;
        pattern_mode = 2'(mode);
        main_state = '0;
        data_from_ram_valid = 1'b0;
        tick();
        chk("busy_after_start", busy, 1);
        chk("err_clear_at_start", error_count, 0);
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!done && i < budget) begin
            tick();
            i++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic end_checks();
        int            exp_err;
        logic [AW-1:0] fa;
        logic [DQ-1:0] fd;
        exp_err = drop;
        fa = '0;
        fd = '0;
        if (ci >= 0 && ci < N - drop && xr != '0) begin
            exp_err++;
            fa = exp_addr(ci);
            fd = exp_word(cur_mode, ci) ^ xr;
        end
        chk("write_count", wr_k, N);
        chk("read_count", rd_k, N);
        chk("busy_at_done", busy, 0);
        chk("we_at_done", write_enable, 0);
        chk("re_at_done", read_enable, 0);
        chk("error_count", error_count, exp_err);
        chk("pass", pass, (exp_err == 0) ? 1 : 0);
        chk("first_err_addr", first_error_address, fa);
        chk("first_err_data", first_error_data, fd);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_we"}, write_enable, 0);
        chk({p, "_re"}, read_enable, 0);
        chk({p, "_addr"}, i_user_data_address, 0);
        chk({p, "_data"}, data_to_ram, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_pass"}, pass, 0);
        chk({p, "_errcnt"}, error_count, 0);
        chk({p, "_feaddr"}, first_error_address, 0);
        chk({p, "_fedata"}, first_error_data, 0);
    endtask

    initial begin
        int gap, m;
        reset = 1'b1; start = 1'b0; pattern_mode = '0; main_state = '0;
        data_from_ram = '0; data_from_ram_valid = 1'b0;
        ci = -1; drop = 0; ms_mode = 0; cur_mode = 0; last_valid_cyc = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        data_from_ram_valid = 1'b1;
        @(negedge clk);
        data_from_ram_valid = 1'b0;
        chk("idle_stray_valid", error_count, 0);

        // Clean incrementing pass.
        start_pass(0, -1, '0, 0, 0);
        wait_done(N * 20);
        end_checks();

        // Single corrupted word in walking-ones mode.
        start_pass(2, 5, 16'h0100, 0, 0);
        wait_done(N * 20);
        end_checks();

        // Last three responses lost: must finish on the read timeout.
        start_pass(0, -1, '0, 3, 0);
        wait_done(N * 30 + TO + 500);
        end_checks();
        gap = cyc - last_valid_cyc;
        chk("timeout_gap_window", (gap >= TO + 1 && gap <= TO + 40) ? 1 : 0, 1);

        // Strobes after completion are ignored.
        @(negedge clk);
        main_state = '0;
        data_from_ram_valid = 1'b1;
        data_from_ram = 16'h5A5A;
        @(negedge clk);
        data_from_ram_valid = 1'b0;
        chk("done_stray_errcnt", error_count, 3);
        chk("done_stray_done", done, 1);

        // Controller leaves the data states every other cycle.
        start_pass(3, -1, '0, 0, 1);
        wait_done(N * 20);
        end_checks();

        // Reset in the middle of the read phase, then a fresh pass.
        start_pass(2, -1, '0, 0, 0);
        for (int i = 0; i < 2000 && rd_k < 10; i++) tick();
        chk("reached_read_phase", (rd_k >= 10) ? 1 : 0, 1);
        @(negedge clk);
        reset = 1'b1;
        main_state = '0;
        data_from_ram_valid = 1'b0;
        rq.delete();
        @(negedge clk);
        chk_zero("midread_reset");
        reset = 1'b0;
        main_state = SB'(ST_RD);
        @(negedge clk);
        chk("post_reset_re", read_enable, 0);
        start_pass(0, -1, '0, 0, 0);
        wait_done(N * 20);
        end_checks();

        // Mode 1: LFSR when built in, otherwise identical to incrementing.
        start_pass(1, -1, '0, 0, 0);
        wait_done(N * 20);
        end_checks();

        for (int p = 0; p < 3; p++) begin
            m = int'($urandom_range(0, 3));
            start_pass(m, int'($urandom_range(0, N - 1)), DQ'($urandom_range(1, 65535)), 0, 0);
            wait_done(N * 20);
            end_checks();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
